// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for a 5-stage RV32 pipeline.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        imem_ready,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        halt_req,
    input  logic        resume,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        mem_wb_stall,
    output logic        halted,
    output logic        bus_err,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [3:0]        DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic [3:0]        drain_cnt;
    logic [3:0]        drain_cnt_nxt;
    logic              bus_err_q;
    logic              bus_err_nxt;

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic mem_stall;
    logic timeout_hit;
    logic frozen;

    assign rs1_hit     = id_uses_rs1 & (ex_rd == id_rs1);
    assign rs2_hit     = id_uses_rs2 & (ex_rd == id_rs2);
    assign load_use    = ex_mem_read & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);
    assign mem_stall   = dmem_req & ~dmem_ready;
    assign timeout_hit = mem_stall & (wait_cnt == WAIT_LAST);
    assign frozen      = (state == ST_HALTED) | (state == ST_ERROR);

    // Pipeline control: fixed priority, purely combinational from state and inputs.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if (!rst) begin
            if (frozen || mem_stall) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_stall = 1'b1;
            end else if (ex_redirect) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (load_use) begin
                // Bubble into EX while ID is held; IF/ID must not also be flushed.
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (state == ST_DRAIN || !imem_ready) begin
                pc_stall     = 1'b1;
                if_id_flush  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        drain_cnt_nxt = drain_cnt;
        bus_err_nxt   = bus_err_q;
        case (state)
            ST_RUN, ST_DRAIN: begin
                if (mem_stall) begin
                    if (timeout_hit) begin
                        state_nxt   = ST_ERROR;
                        bus_err_nxt = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    wait_cnt_nxt = '0;
                    if (state == ST_RUN) begin
                        if (halt_req) begin
                            state_nxt     = ST_DRAIN;
                            drain_cnt_nxt = 4'd0;
                        end
                    end else if (!load_use) begin
                        // A load-use bubble does not count toward the drain.
                        if (drain_cnt == DRAIN_LAST) begin
                            state_nxt     = ST_HALTED;
                            drain_cnt_nxt = 4'd0;
                        end else begin
                            drain_cnt_nxt = drain_cnt + 4'd1;
                        end
                    end
                end
            end
            ST_HALTED: begin
                wait_cnt_nxt = '0;
                if (resume) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            drain_cnt <= 4'd0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            drain_cnt <= drain_cnt_nxt;
            bus_err_q <= bus_err_nxt;
        end
    end

    assign halted  = ~rst & (state == ST_HALTED);
    assign bus_err = bus_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (pc_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (id_ex_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

`default_nettype wire
